// File: rtl/riscv_pkg.sv
// Shared RV32 definitions for the pipeline front end: word width, the NOP
// encoding, the default reset PC and the fetch-queue entry layout.
package riscv_pkg;

  localparam int          XLEN             = 32;
  localparam logic [31:0] RV_NOP           = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_skid_fifo.sv
// Two-entry skid queue between the imem read port and decode. The head entry
// is visible combinationally; flush empties the queue and overrides push/pop.
module fetch_skid_fifo
  import riscv_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output logic [1:0]   count
);

  fetch_entry_t mem [2];
  logic         rd_ptr;
  logic         wr_ptr;
  logic         push_eff;
  logic         pop_eff;

  assign push_eff = push && !flush;
  assign pop_eff  = pop && (count != 2'd0) && !flush;
  assign head     = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push_eff) wr_ptr <= ~wr_ptr;
      if (pop_eff)  rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push_eff} - {1'b0, pop_eff};
    end
  end

  // Storage carries no reset; count gates every use of it.
  always_ff @(posedge clk) begin
    if (push_eff) mem[wr_ptr] <= push_data;
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push_eff && !pop_eff && count == 2'd2));

endmodule

// File: rtl/fetch_unit.sv
// RV32 instruction-fetch stage: owns the PC, issues imem reads, queues the
// returned words with their PCs and hands them to decode; execute may redirect.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter int          INST_MEMORY_SIZE = 1024,
  parameter int          ADDR_WIDTH       = $clog2(INST_MEMORY_SIZE),
  parameter logic [31:0] RESET_PC         = DEFAULT_RESET_PC
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [31:0]           imem_rdata,
  input  logic                  redirect_valid,
  input  logic [31:0]           redirect_pc,
  input  logic                  id_ready,
  output logic                  id_valid,
  output logic [31:0]           id_instr,
  output logic [31:0]           id_pc,
  output logic                  misalign_err
);

  logic [31:0]  pc;
  logic         inflight;
  logic [31:0]  inflight_pc;
  logic         issue;
  logic         pop;
  logic [2:0]   occupancy;
  logic [1:0]   count;
  fetch_entry_t push_data;
  fetch_entry_t head;

  assign imem_addr = pc[ADDR_WIDTH-1:0];
  assign id_valid  = (count != 2'd0);
  assign pop       = id_valid && id_ready;

  // Entries queued plus the read still in flight, net of this cycle's pop,
  // must leave room for the word the new issue will return next cycle.
  assign occupancy = {1'b0, count} + {2'b0, inflight} - {2'b0, pop};
  assign issue     = !redirect_valid && (occupancy < 3'd2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc           <= RESET_PC;
      inflight     <= 1'b0;
      misalign_err <= 1'b0;
    end else begin
      misalign_err <= redirect_valid && (redirect_pc[1:0] != 2'b00);
      if (redirect_valid) begin
        pc       <= {redirect_pc[31:2], 2'b00};
        inflight <= 1'b0;
      end else begin
        inflight <= issue;
        if (issue) pc <= pc + 32'd4;
      end
    end
  end

  // imem request boundary: remember which PC the returning word belongs to.
  always_ff @(posedge clk) begin
    if (issue) inflight_pc <= pc;
  end

  assign push_data.pc    = inflight_pc;
  assign push_data.instr = imem_rdata;

  fetch_skid_fifo u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight && !redirect_valid),
    .push_data (push_data),
    .pop       (pop),
    .flush     (redirect_valid),
    .head      (head),
    .count     (count)
  );

  assign id_instr = id_valid ? head.instr : RV_NOP;
  assign id_pc    = id_valid ? head.pc    : 32'd0;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a registered instruction memory whose
// word i holds 32'hA000_0000 + i.
module tb_fetch_unit;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_rdata;
  logic          redirect_valid;
  logic [31:0]   redirect_pc;
  logic          id_ready;
  logic          id_valid;
  logic [31:0]   id_instr;
  logic [31:0]   id_pc;
  logic          misalign_err;

  int total = 0;
  int bad   = 0;

  logic [31:0] imem [256];

  fetch_unit #(.INST_MEMORY_SIZE(1024)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_ready       (id_ready),
    .id_valid       (id_valid),
    .id_instr       (id_instr),
    .id_pc          (id_pc),
    .misalign_err   (misalign_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) imem_rdata <= imem[imem_addr[AW-1:2]];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    rst_n = 1'b0; id_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'd0;
    repeat (2) @(negedge clk);
    total++;
    if (id_valid !== 1'b0 || id_instr !== 32'h0000_0013 || id_pc !== 32'd0 ||
        misalign_err !== 1'b0 || imem_addr !== 10'd0) begin
      bad++;
      $display("FAIL reset_state: valid=%b instr=%h pc=%h mis=%b addr=%h want 0/00000013/0/0/0",
               id_valid, id_instr, id_pc, misalign_err, imem_addr);
    end
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (id_valid !== 1'b0) begin
      bad++; $display("FAIL reset_first_cycle: valid=%b want 0", id_valid);
    end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      total++;
      if (id_valid !== 1'b1 || id_pc !== 32'(4*k) || id_instr !== 32'hA000_0000 + 32'(k)) begin
        bad++;
        $display("FAIL stream_%0d: valid=%b pc=%h instr=%h want 1/%h/%h",
                 k, id_valid, id_pc, id_instr, 32'(4*k), 32'hA000_0000 + 32'(k));
      end
    end
  endtask

  // Entry: id_pc=0x14 shown, id_ready=1.
  task automatic test_stall();
    id_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      total++;
      if (id_valid !== 1'b1 || id_pc !== 32'h14 || id_instr !== 32'hA000_0005) begin
        bad++;
        $display("FAIL stall_hold_%0d: valid=%b pc=%h instr=%h want 1/00000014/a0000005",
                 k, id_valid, id_pc, id_instr);
      end
    end
    total++;
    if (imem_addr !== 10'h01C) begin
      bad++; $display("FAIL stall_pc_stop: addr=%h want 01c", imem_addr);
    end
    id_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      total++;
      if (id_valid !== 1'b1 || id_pc !== 32'h18 + 32'(4*k) ||
          id_instr !== 32'hA000_0006 + 32'(k)) begin
        bad++;
        $display("FAIL stall_resume_%0d: valid=%b pc=%h instr=%h want 1/%h/%h", k,
                 id_valid, id_pc, id_instr, 32'h18 + 32'(4*k), 32'hA000_0006 + 32'(k));
      end
    end
  endtask

  task automatic test_redirect();
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    @(negedge clk);
    redirect_valid = 1'b0;
    total++;
    if (id_valid !== 1'b0 || imem_addr !== 10'h100 || misalign_err !== 1'b0) begin
      bad++;
      $display("FAIL redirect_next: valid=%b addr=%h mis=%b want 0/100/0",
               id_valid, imem_addr, misalign_err);
    end
    @(negedge clk);
    total++;
    if (id_valid !== 1'b0) begin
      bad++; $display("FAIL redirect_no_stale: valid=%b pc=%h want valid 0", id_valid, id_pc);
    end
    @(negedge clk);
    total++;
    if (id_valid !== 1'b1 || id_pc !== 32'h100 || id_instr !== 32'hA000_0040) begin
      bad++;
      $display("FAIL redirect_target: valid=%b pc=%h instr=%h want 1/00000100/a0000040",
               id_valid, id_pc, id_instr);
    end
    @(negedge clk);
    total++;
    if (id_pc !== 32'h104 || id_instr !== 32'hA000_0041) begin
      bad++; $display("FAIL redirect_follow: pc=%h instr=%h want 00000104/a0000041", id_pc, id_instr);
    end
  endtask

  // Entry: id_pc=0x104 shown, FIFO holding 0x104 with 0x108 in flight.
  task automatic test_redirect_full();
    id_ready = 1'b0;
    repeat (3) @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    @(negedge clk);
    redirect_valid = 1'b0;
    total++;
    if (id_valid !== 1'b0) begin
      bad++; $display("FAIL full_flush: valid=%b pc=%h want valid 0", id_valid, id_pc);
    end
    @(negedge clk);
    @(negedge clk);
    total++;
    if (id_valid !== 1'b1 || id_pc !== 32'h200 || id_instr !== 32'hA000_0080) begin
      bad++;
      $display("FAIL full_target_first: valid=%b pc=%h instr=%h want 1/00000200/a0000080",
               id_valid, id_pc, id_instr);
    end
    id_ready = 1'b1;
    for (int k = 1; k < 3; k++) begin
      @(negedge clk);
      total++;
      if (id_pc !== 32'h200 + 32'(4*k) || id_instr !== 32'hA000_0080 + 32'(k)) begin
        bad++;
        $display("FAIL full_after_%0d: pc=%h instr=%h want %h/%h", k, id_pc, id_instr,
                 32'h200 + 32'(4*k), 32'hA000_0080 + 32'(k));
      end
    end
  endtask

  task automatic test_misalign();
    redirect_valid = 1'b1; redirect_pc = 32'h102;
    @(negedge clk);
    redirect_valid = 1'b0;
    total++;
    if (misalign_err !== 1'b1 || id_valid !== 1'b0 || imem_addr !== 10'h100) begin
      bad++;
      $display("FAIL misalign_pulse: mis=%b valid=%b addr=%h want 1/0/100",
               misalign_err, id_valid, imem_addr);
    end
    @(negedge clk);
    total++;
    if (misalign_err !== 1'b0) begin
      bad++; $display("FAIL misalign_one_cycle: mis=%b want 0", misalign_err);
    end
    @(negedge clk);
    total++;
    if (id_valid !== 1'b1 || id_pc !== 32'h100 || id_instr !== 32'hA000_0040) begin
      bad++;
      $display("FAIL misalign_aligned: valid=%b pc=%h instr=%h want 1/00000100/a0000040",
               id_valid, id_pc, id_instr);
    end
  endtask

  task automatic test_midreset_and_wrap();
    rst_n = 1'b0;
    #1;
    total++;
    if (id_valid !== 1'b0 || id_pc !== 32'd0 || id_instr !== 32'h0000_0013 || imem_addr !== 10'd0) begin
      bad++;
      $display("FAIL midreset_async: valid=%b pc=%h instr=%h addr=%h want 0/0/00000013/0",
               id_valid, id_pc, id_instr, imem_addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (id_valid !== 1'b0) begin
      bad++; $display("FAIL midreset_gap: valid=%b want 0", id_valid);
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      total++;
      if (id_valid !== 1'b1 || id_pc !== 32'(4*k) || id_instr !== 32'hA000_0000 + 32'(k)) begin
        bad++;
        $display("FAIL midreset_restart_%0d: valid=%b pc=%h instr=%h want 1/%h/%h", k,
                 id_valid, id_pc, id_instr, 32'(4*k), 32'hA000_0000 + 32'(k));
      end
    end
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    @(negedge clk);
    redirect_valid = 1'b0;
    total++;
    if (imem_addr !== 10'h3FC || id_valid !== 1'b0) begin
      bad++; $display("FAIL wrap_target_addr: addr=%h valid=%b want 3fc/0", imem_addr, id_valid);
    end
    @(negedge clk);
    total++;
    if (imem_addr !== 10'h000) begin
      bad++; $display("FAIL wrap_pc_zero: addr=%h want 000", imem_addr);
    end
    @(negedge clk);
    total++;
    if (id_valid !== 1'b1 || id_pc !== 32'hFFFF_FFFC || id_instr !== 32'hA000_00FF) begin
      bad++;
      $display("FAIL wrap_last: valid=%b pc=%h instr=%h want 1/fffffffc/a00000ff",
               id_valid, id_pc, id_instr);
    end
    @(negedge clk);
    total++;
    if (id_valid !== 1'b1 || id_pc !== 32'h0 || id_instr !== 32'hA000_0000) begin
      bad++;
      $display("FAIL wrap_first: valid=%b pc=%h instr=%h want 1/00000000/a0000000",
               id_valid, id_pc, id_instr);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) imem[i] = 32'hA000_0000 + 32'(i);
    test_reset();
    test_stall();
    test_redirect();
    test_redirect_full();
    test_misalign();
    test_midreset_and_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
